imem_loader: RTL
================

Name: imem_loader

Overview:
- Hardware writer for the CPU instruction memory: receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them to consecutive word addresses from 0.
- Holds the core idle (start low) while loading; raises start once the image is complete.
- Sits between a host byte link (UART/JTAG bridge) and the Instruction_Memory write port / CPU start_i. Replaces the simulation-only $readmemb preload path.

Parameters:
- ADDR_W, 8, word-address width of instruction memory (2^ADDR_W words, 256 by default).
- LEN_W, 16, width of the word-count header field, in bits. Must be ≥ ADDR_W+1.

Ports:
- clk_i, in, 1, clock; all state updates on the rising edge.
- rst_i, in, 1, asynchronous active-low reset.
- load_req_i, in, 1, single-cycle pulse that starts or restarts a load session.
- byte_valid_i, in, 1, a byte is offered on byte_data_i.
- byte_data_i, in, 8, stream byte.
- byte_ready_o, out, 1, loader accepts a byte this cycle. A transfer occurs when byte_valid_i and byte_ready_o are both high on the same edge.
- imem_we_o, out, 1, instruction-memory write strobe, one cycle per word.
- imem_addr_o, out, ADDR_W, word address of the write.
- imem_data_o, out, 32, word to write.
- cpu_start_o, out, 1, drives CPU start_i; high only in DONE.
- busy_o, out, 1, a load session is in progress.
- done_o, out, 1, image fully written.
- err_o, out, 1, header rejected.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0.
  - Internal word index, byte counter and header length are cleared.
- Stream format: LEN low byte, LEN high byte (LEN_W=16), then LEN words of 4 bytes each, LSB first.
- States:
  - IDLE: byte_ready_o=0. On load_req_i go to HDR0 and set busy_o=1.
  - HDR0: byte_ready_o=1. On transfer, latch len[7:0] and go to HDR1.
  - HDR1: byte_ready_o=1. On transfer, latch len[15:8], then:
    - len > 2^ADDR_W: go to ERR.
    - len == 0: go to FILL if the fill feature is compiled in, otherwise DONE.
    - otherwise: go to DATA.
  - DATA: byte_ready_o=1.
    - Each transfer shifts the byte into the assembly register at position byte_cnt (0..3).
    - On the transfer with byte_cnt==3, on the next cycle: imem_we_o=1, imem_addr_o=word index, imem_data_o=assembled word. The word index then increments and byte_cnt returns to 0.
    - Write latency is exactly 1 cycle after the 4th byte's handshake.
    - byte_ready_o stays 1 during the write cycle, so there is no stall.
    - After the write of word len-1, go to FILL if compiled in, otherwise DONE. byte_ready_o is 0 from that cycle on.
  - FILL (feature only): see Optional Feature.
  - DONE: done_o=1, cpu_start_o=1, busy_o=0, byte_ready_o=0.
  - ERR: err_o=1, busy_o=0, byte_ready_o=0, cpu_start_o=0. No memory writes.
- Exiting DONE or ERR: only via load_req_i, which goes to HDR0. On that edge cpu_start_o, done_o and err_o clear.
- load_req_i while busy (HDR0/HDR1/DATA/FILL):
  - Restarts at HDR0; word index and byte_cnt are cleared.
  - A partial word is discarded; words already written stay in memory.
  - A write strobe pending on the same edge is still issued.
- Bytes offered while byte_ready_o=0 are ignored, not queued.
- Boundaries:
  - The word index is ADDR_W+1 bits wide; the last legal address is 2^ADDR_W−1, and len==2^ADDR_W is accepted.
  - imem_addr_o never wraps, because the header check prevents overflow.
- imem_addr_o and imem_data_o hold their last value when imem_we_o=0.

Optional Feature:
- Macro: IMEM_LOADER_ZERO_FILL_EN.
- Defined:
  - After the last data word (or immediately when len==0), the FILL state writes 32'h0 to addresses len..2^ADDR_W−1, one per cycle, with imem_we_o=1 on each.
  - byte_ready_o=0 throughout FILL.
  - Go to DONE the cycle after the write to address 2^ADDR_W−1.
  - If len==2^ADDR_W, FILL is skipped.
  - Stale code from a previous longer image is therefore zeroed.
- Not defined: the FILL state does not exist; go straight to DONE. Memory above len is untouched.

Test Plan:
- Reset: hold rst_i=0 mid-session, then release -> all outputs 0, IDLE, no imem_we_o.
- Basic load, no fill: load_req_i, then bytes 02 00 13 00 00 00 93 00 50 00 with byte_valid_i=1 every cycle -> imem_we_o at addr 0 with 0x00000013, then addr 1 with 0x00500093, each one cycle after its 4th byte; then done_o=1, cpu_start_o=1, busy_o=0. Repeat with byte_valid_i toggled every other cycle -> identical writes.
- Empty image: header 00 00 -> no writes; done_o=1 the cycle after the HDR1 transfer.
- Oversize header: 01 01 (257) with ADDR_W=8 -> err_o=1, cpu_start_o=0, byte_ready_o=0, zero writes. A following load_req_i clears err_o.
- Restart mid-word: header 01 00, data bytes AA BB, then load_req_i, then 01 00 11 22 33 44 -> single write at addr 0 of 0x44332211, AA/BB never written.
- Zero fill (macro defined): header 01 00 plus word 13 00 00 00 -> write addr 0 = 0x13, then 255 consecutive zero writes to addresses 1..255, then done_o=1. Exactly 256 strobes total.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader for the CPU instruction memory.
// Receives a LEN header (2 bytes, LSB first) followed by LEN little-endian
// 32-bit words and writes them to word addresses 0..LEN-1, then raises
// cpu_start_o. Optional macro IMEM_LOADER_ZERO_FILL_EN zeroes the rest of
// the memory (addresses LEN..2^ADDR_W-1) before starting the core.
module imem_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_req_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              cpu_start_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    // Word index is one bit wider so a full 2^ADDR_W image can be counted.
    localparam int unsigned      IDX_W   = ADDR_W + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
`ifdef IMEM_LOADER_ZERO_FILL_EN
        S_FILL,
`else
        S_LAST,
`endif
        S_DONE,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [23:0]        asm_q, asm_d;
    logic [7:0]         len_lo_q, len_lo_d;
    logic [IDX_W-1:0]   len_q, len_d;

    logic               byte_ready_q, byte_ready_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               hs;
    logic [LEN_W-1:0]   hdr_len;
    logic [IDX_W-1:0]   idx_inc;

    assign hs      = byte_valid_i & byte_ready_q;
    assign hdr_len = LEN_W'({byte_data_i, len_lo_q});
    assign idx_inc = idx_q + IDX_W'(1);

    // State and registered-output update.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            asm_q        <= '0;
            len_lo_q     <= '0;
            len_q        <= '0;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            byte_ready_q <= byte_ready_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Next-state, word assembly and write generation; outputs follow state_d.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;

        case (state_q)
            S_IDLE: ;
            S_HDR0: begin
                if (hs) begin
                    len_lo_d = byte_data_i;
                    state_d  = S_HDR1;
                end
            end
            S_HDR1: begin
                if (hs) begin
                    if (hdr_len > MAX_LEN) begin
                        state_d = S_ERR;
                    end else begin
                        len_d = IDX_W'(hdr_len);
                        idx_d = '0;
                        cnt_d = '0;
                        if (hdr_len == '0) begin
`ifdef IMEM_LOADER_ZERO_FILL_EN
                            state_d = S_FILL;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (hs) begin
                    if (cnt_q == 2'd3) begin
                        we_d   = 1'b1;
                        addr_d = ADDR_W'(idx_q);
                        data_d = {byte_data_i, asm_q};
                        idx_d  = idx_inc;
                        cnt_d  = '0;
                        if (idx_inc == len_q) begin
`ifdef IMEM_LOADER_ZERO_FILL_EN
                            state_d = S_FILL;
`else
                            state_d = S_LAST;
`endif
                        end
                    end else begin
                        case (cnt_q)
                            2'd0:    asm_d[7:0]   = byte_data_i;
                            2'd1:    asm_d[15:8]  = byte_data_i;
                            default: asm_d[23:16] = byte_data_i;
                        endcase
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
`ifdef IMEM_LOADER_ZERO_FILL_EN
            // Zero one word per cycle until the index passes the top address.
            S_FILL: begin
                if (idx_q[ADDR_W]) begin
                    state_d = S_DONE;
                end else begin
                    we_d   = 1'b1;
                    addr_d = ADDR_W'(idx_q);
                    data_d = '0;
                    idx_d  = idx_inc;
                end
            end
`else
            // Cycle carrying the final word's write strobe.
            S_LAST: state_d = S_DONE;
`endif
            S_DONE: ;
            S_ERR:  ;
            default: state_d = S_IDLE;
        endcase

        // A load request restarts from any state; a write computed above still goes out.
        if (load_req_i) begin
            state_d = S_HDR0;
            idx_d   = '0;
            cnt_d   = '0;
        end

        byte_ready_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
        busy_d       = (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_ERR);
        done_d       = (state_d == S_DONE);
        start_d      = (state_d == S_DONE);
        err_d        = (state_d == S_ERR);
    end

    assign byte_ready_o = byte_ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_data_o  = data_q;
    assign cpu_start_o  = start_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
